// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : EX-stage consumer of the ALU flag interface. Holds the
//               architectural Z/V/N flags, resolves conditional branches
//               against the registered flags, issues the PC redirect,
//               sequences the wrong-path flush and counts taken branches.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, all state on posedge
//   rst_n        in   synchronous active-low reset (overrides stall)
//   stall        in   global pipeline stall, freezes all state
//   zr_in/ov_in/neg_in   in   ALU zero / overflow / sign flags
//   we_zr        in   update Z
//   we_vn        in   update V and N
//   br_valid     in   EX holds a conditional branch
//   br_cond      in   [2:0] condition code
//   br_target    in   [15:0] branch target
//   Z, V, N      out  registered flags
//   br_taken     out  one-cycle taken pulse
//   pc_redirect  out  [15:0] target, valid while br_taken=1
//   flush_IF_ID, flush_ID_EX  out  squash wrong-path stages
//   busy         out  flush sequence in progress
//   taken_cnt    out  [CNT_W-1:0] saturating taken-branch count
// ============================================================================
module flag_branch_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             zr_in,
    input  logic             ov_in,
    input  logic             neg_in,
    input  logic             we_zr,
    input  logic             we_vn,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic [15:0]      br_target,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             br_taken,
    output logic [15:0]      pc_redirect,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             busy,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // FLUSH is entered already showing the first flush cycle, so the
    // remaining-cycle counter is loaded with one less than the width.
    localparam logic [2:0]       c_FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

    state_t           r_state, w_state;
    logic [2:0]       r_cnt, w_cnt;
    logic             r_z, r_v, r_n, w_z, w_v, w_n;
    logic             r_taken, w_taken;
    logic [15:0]      r_pc, w_pc;
    logic             r_flush, w_flush;
    logic [CNT_W-1:0] r_tcnt, w_tcnt;
    logic             w_cond;

    // Condition uses the flags as registered, before this cycle's update.
    always_comb begin
        w_cond = 1'b0;
        case (br_cond)
            3'b000:  w_cond = ~r_z;
            3'b001:  w_cond = r_z;
            3'b010:  w_cond = ~r_z & ~r_n;
            3'b011:  w_cond = r_n;
            3'b100:  w_cond = ~r_n;
            3'b101:  w_cond = r_n | r_z;
            3'b110:  w_cond = r_v;
            default: w_cond = 1'b1;
        endcase
    end

    // Next-state and next-output logic; a stall leaves every value as is.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_z     = r_z;
        w_v     = r_v;
        w_n     = r_n;
        w_taken = r_taken;
        w_pc    = r_pc;
        w_flush = r_flush;
        w_tcnt  = r_tcnt;
        if (!stall) begin
            if (we_zr) begin
                w_z = zr_in;
            end
            if (we_vn) begin
                w_v = ov_in;
                w_n = neg_in;
            end
            case (r_state)
                ST_IDLE: begin
                    if (br_valid && w_cond) begin
                        w_state = ST_FLUSH;
                        w_taken = 1'b1;
                        w_pc    = br_target;
                        w_flush = 1'b1;
                        w_cnt   = c_FLUSH_LOAD;
                        if (r_tcnt != c_CNT_MAX) begin
                            w_tcnt = r_tcnt + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Branches seen here are on the wrong path and ignored.
                    w_taken = 1'b0;
                    if (r_cnt != 3'd0) begin
                        w_cnt = r_cnt - 3'd1;
                    end else begin
                        w_flush = 1'b0;
                        w_state = ST_IDLE;
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
            r_n     <= 1'b0;
            r_taken <= 1'b0;
            r_pc    <= 16'h0000;
            r_flush <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_z     <= w_z;
            r_v     <= w_v;
            r_n     <= w_n;
            r_taken <= w_taken;
            r_pc    <= w_pc;
            r_flush <= w_flush;
            r_tcnt  <= w_tcnt;
        end
    end

    assign Z           = r_z;
    assign V           = r_v;
    assign N           = r_n;
    assign br_taken    = r_taken;
    assign pc_redirect = r_pc;
    assign flush_IF_ID = r_flush;
    assign flush_ID_EX = r_flush;
    assign busy        = r_flush;
    assign taken_cnt   = r_tcnt;

endmodule
`default_nettype wire

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumer end of the EX-stage ALU flag interface.
- Captures the ALU's zero, overflow and negative outputs into an architectural flag register, under per-flag write enables.
- Resolves conditional branches in EX against the registered flags, drives the PC redirect, and sequences the pipeline flush of wrong-path instructions.
- Keeps a saturating count of taken branches for debug.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_IF_ID/flush_ID_EX stay asserted after a taken branch (legal 1..7).
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- stall  input  1  global pipeline stall; freezes all state.
- zr_in  input  1  ALU zero flag (EX, combinational).
- ov_in  input  1  ALU saturation/overflow flag (EX).
- neg_in  input  1  ALU sign flag (EX).
- we_zr  input  1  EX instruction updates Z (all ALU ops).
- we_vn  input  1  EX instruction updates V and N (ADD/SUB/PADD only).
- br_valid  input  1  EX holds a conditional branch.
- br_cond  input  3  condition code.
- br_target  input  16  branch target address from EX.
- Z, V, N  output  1 each  registered flags.
- br_taken  output  1  registered; branch resolved taken.
- pc_redirect  output  16  registered target; valid while br_taken=1.
- flush_IF_ID, flush_ID_EX  output  1 each  squash wrong-path stages.
- busy  output  1  FSM in FLUSH.
- taken_cnt  output  CNT_W  saturating taken-branch count.

Behaviour:
- Reset, when rst_n=0 at posedge: Z=V=N=0, br_taken=0, pc_redirect=0, both flushes 0, busy=0, taken_cnt=0, FSM=IDLE. Reset overrides stall and aborts an in-progress flush.
- Stall: with stall=1 and rst_n=1, no register changes. This covers flags, FSM, counter, br_taken and pc_redirect; outputs hold their values.
- Flag update, when stall=0: Z<=zr_in if we_zr; V<=ov_in and N<=neg_in if we_vn. Flags without an enable hold.
- Condition evaluation:
  - Evaluate the condition combinationally from the registered Z/V/N, i.e. the flags as they stood before this cycle's update.
  - A flag write and a branch in the same cycle therefore use the old flags. Instruction order guarantees the setter precedes the branch.
- Condition codes:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: !N
  - 101 LE: N|Z
  - 110 OV: V
  - 111 always
- FSM states: IDLE, FLUSH.
- IDLE:
  - If stall=0, br_valid=1 and the condition is true: next cycle br_taken=1, pc_redirect=br_target, flush_IF_ID=flush_ID_EX=1, busy=1, cnt<=FLUSH_CYCLES-1, state=FLUSH.
  - taken_cnt increments, saturating at all-ones.
  - A not-taken branch produces no outputs.
- FLUSH:
  - br_taken falls to 0 after exactly one non-stalled cycle; pc_redirect holds its last value.
  - Flush outputs stay 1 while cnt!=0; cnt decrements each non-stalled cycle.
  - When cnt==0, the next edge deasserts the flushes and busy and returns to IDLE. Flush width is therefore exactly FLUSH_CYCLES non-stalled cycles.
  - br_valid is ignored in FLUSH (wrong-path branch): no redirect, no count.
  - Flag writes still occur if enables are high. Upstream gates those enables with the flush.
- Latency: branch in EX at cycle t → br_taken/pc_redirect/flushes high in cycle t+1.
- FLUSH_CYCLES=1: state returns to IDLE after one cycle. A branch presented in that following cycle is evaluated normally.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 → all outputs 0; br_valid with cond=001 and Z=0 yields br_taken=0.
- Flag capture: zr_in=1, ov_in=1, neg_in=1 with we_zr=1, we_vn=0 → Z=1, V=0, N=0. Next cycle, with we_vn=1 and inputs 0/1/1 and we_zr=0 → Z=1, V=1, N=1.
- Condition sweep: for each of the 8 flag combinations × 8 codes, issue br_target=16'h1234 → br_taken matches the condition table, pc_redirect=16'h1234, flushes high for 2 cycles, taken_cnt increments only on taken.
- Flush shadow: a taken branch, then br_valid=1 cond=111 target=16'hBEEF in the next two cycles → no second redirect, pc_redirect stays 16'h1234, taken_cnt +1 total.
- Stall mid-flush: a taken branch, then stall=1 for 3 cycles in FLUSH → outputs frozen; after release the flushes last exactly one more cycle (FLUSH_CYCLES=2).
- Reset mid-flush and saturation: rst_n=0 during FLUSH → next cycle IDLE with all outputs 0. Preload taken_cnt to 16'hFFFF via repeated taken branches → the next taken branch leaves it at 16'hFFFF.
